// File: rtl/conv_share_ctrl.sv
// Purpose : round-robin sequencer sharing one combinational 4-bit code converter
//           between two level-request clients.
// Latency : a request sampled at edge T acks in cycle T+SETTLE_CYCLES+1..+2.
// Backpres: one transaction at a time; a waiting requester simply holds req high.
// Ports   : clk/rst_n, per-client req/din in and ack/dout out, conv_a..d drive the
//           converter, conv_w..z return its result, busy and done_cnt status.
module conv_share_ctrl #(
   parameter int SETTLE_CYCLES = 1,   // legal 1..15
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [3:0]       din0,
   output logic             ack0,
   output logic [3:0]       dout0,
   input  logic             req1,
   input  logic [3:0]       din1,
   output logic             ack1,
   output logic [3:0]       dout1,
   output logic             conv_a,
   output logic             conv_b,
   output logic             conv_c,
   output logic             conv_d,
   input  logic             conv_w,
   input  logic             conv_x,
   input  logic             conv_y,
   input  logic             conv_z,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

   // Settle count is held in 4 bits, so the counter covers the full 1..15 range.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             gnt_q, gnt_d;
   logic             last_q, last_d;
   logic [3:0]       dout0_q, dout0_d;
   logic [3:0]       dout1_q, dout1_d;
   logic [CNT_W-1:0] done_q, done_d;
   logic             pick;
   logic [3:0]       conv_res;

   assign conv_res = {conv_w, conv_x, conv_y, conv_z};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      dout0_d = dout0_q;
      dout1_d = dout1_q;
      done_d  = done_q;
      // On contention the requester that was not served last wins.
      pick    = (req0 && req1) ? ~last_q : req1;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt_d   = pick;
               op_d    = pick ? din1 : din0;
               cnt_d   = SETTLE_LOAD;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == 4'd0) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         CAPTURE: begin
            if (gnt_q) begin
               dout1_d = conv_res;
            end else begin
               dout0_d = conv_res;
            end
            state_d = RESP;
         end
         RESP: begin
            last_d  = gnt_q;
            done_d  = done_q + CNT_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= 4'd0;
         cnt_q   <= 4'd0;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         dout0_q <= 4'd0;
         dout1_q <= 4'd0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         dout0_q <= dout0_d;
         dout1_q <= dout1_d;
         done_q  <= done_d;
      end
   end

   // Converter inputs come straight from the operand register, so they stay
   // stable for the whole transaction and hold afterwards.
   assign conv_a   = op_q[3];
   assign conv_b   = op_q[2];
   assign conv_c   = op_q[1];
   assign conv_d   = op_q[0];

   assign ack0     = (state_q == RESP) && !gnt_q;
   assign ack1     = (state_q == RESP) &&  gnt_q;
   assign dout0    = dout0_q;
   assign dout1    = dout1_q;
   assign busy     = (state_q != IDLE);
   assign done_cnt = done_q;

endmodule

// File: tb/tb_conv_share_ctrl.sv
module tb_conv_share_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: SETTLE_CYCLES=1, CNT_W=8
   logic       a_req0 = 0, a_req1 = 0;
   logic [3:0] a_din0 = 0, a_din1 = 0;
   logic       a_ack0, a_ack1, a_busy;
   logic [3:0] a_dout0, a_dout1, a_cin;
   logic [7:0] a_done;

   // Instance B: SETTLE_CYCLES=4
   logic       b_req0 = 0, b_req1 = 0;
   logic [3:0] b_din0 = 0, b_din1 = 0;
   logic       b_ack0, b_ack1, b_busy;
   logic [3:0] b_dout0, b_dout1, b_cin;
   logic [7:0] b_done;

   // Instance C: SETTLE_CYCLES=1, CNT_W=2
   logic       c_req0 = 0, c_req1 = 0;
   logic [3:0] c_din0 = 0, c_din1 = 0;
   logic       c_ack0, c_ack1, c_busy;
   logic [3:0] c_dout0, c_dout1, c_cin;
   logic [1:0] c_done;

   conv_share_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_n),
      .req0(a_req0), .din0(a_din0), .ack0(a_ack0), .dout0(a_dout0),
      .req1(a_req1), .din1(a_din1), .ack1(a_ack1), .dout1(a_dout1),
      .conv_a(a_cin[3]), .conv_b(a_cin[2]), .conv_c(a_cin[1]), .conv_d(a_cin[0]),
      .conv_w(~a_cin[3]), .conv_x(~a_cin[2]), .conv_y(~a_cin[1]), .conv_z(~a_cin[0]),
      .busy(a_busy), .done_cnt(a_done));

   conv_share_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) u_b (
      .clk(clk), .rst_n(rst_n),
      .req0(b_req0), .din0(b_din0), .ack0(b_ack0), .dout0(b_dout0),
      .req1(b_req1), .din1(b_din1), .ack1(b_ack1), .dout1(b_dout1),
      .conv_a(b_cin[3]), .conv_b(b_cin[2]), .conv_c(b_cin[1]), .conv_d(b_cin[0]),
      .conv_w(~b_cin[3]), .conv_x(~b_cin[2]), .conv_y(~b_cin[1]), .conv_z(~b_cin[0]),
      .busy(b_busy), .done_cnt(b_done));

   conv_share_ctrl #(.SETTLE_CYCLES(1), .CNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_n),
      .req0(c_req0), .din0(c_din0), .ack0(c_ack0), .dout0(c_dout0),
      .req1(c_req1), .din1(c_din1), .ack1(c_ack1), .dout1(c_dout1),
      .conv_a(c_cin[3]), .conv_b(c_cin[2]), .conv_c(c_cin[1]), .conv_d(c_cin[0]),
      .conv_w(~c_cin[3]), .conv_x(~c_cin[2]), .conv_y(~c_cin[1]), .conv_z(~c_cin[0]),
      .busy(c_busy), .done_cnt(c_done));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for an ack on instance A or C; returns which ack fired.
   task automatic wait_ack(input int inst, output int which);
      logic k0, k1;
      logic timed_out;
      timed_out = 1'b1;
      which = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         k0 = (inst == 0) ? a_ack0 : c_ack0;
         k1 = (inst == 0) ? a_ack1 : c_ack1;
         if (k0 || k1) begin
            timed_out = 1'b0;
            which = k1 ? 1 : 0;
            chk("ack_exclusive", {31'd0, k0 & k1}, 32'd0);
            break;
         end
      end
      chk("ack_timeout", {31'd0, timed_out}, 32'd0);
   endtask

   initial begin
      int which;

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      chk("rst_busy",  {31'd0, a_busy}, 32'd0);
      chk("rst_ack0",  {31'd0, a_ack0}, 32'd0);
      chk("rst_ack1",  {31'd0, a_ack1}, 32'd0);
      chk("rst_dout0", {28'd0, a_dout0}, 32'd0);
      chk("rst_dout1", {28'd0, a_dout1}, 32'd0);
      chk("rst_conv",  {28'd0, a_cin}, 32'd0);
      chk("rst_done",  {24'd0, a_done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---------------- test 1: single request, SETTLE=1 ----------------
      a_req0 = 1'b1; a_din0 = 4'b0011;
      @(negedge clk);                       // after edge T
      a_req0 = 1'b0;
      chk("t1_conv_T",  {28'd0, a_cin}, 32'h3);
      chk("t1_busy_T",  {31'd0, a_busy}, 32'd1);
      chk("t1_ack0_T",  {31'd0, a_ack0}, 32'd0);
      @(negedge clk);                       // after T+1
      chk("t1_conv_T1", {28'd0, a_cin}, 32'h3);
      chk("t1_ack0_T1", {31'd0, a_ack0}, 32'd0);
      @(negedge clk);                       // after T+2: ack cycle
      chk("t1_ack0_T2", {31'd0, a_ack0}, 32'd1);
      chk("t1_ack1_T2", {31'd0, a_ack1}, 32'd0);
      chk("t1_dout0",   {28'd0, a_dout0}, 32'hC);
      @(negedge clk);                       // after T+3
      chk("t1_ack0_T3", {31'd0, a_ack0}, 32'd0);
      chk("t1_busy_T3", {31'd0, a_busy}, 32'd0);
      chk("t1_done",    {24'd0, a_done}, 32'd1);

      // ---------------- test 2: contention alternates ----------------
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      a_req0 = 1'b1; a_req1 = 1'b1; a_din0 = 4'h5; a_din1 = 4'hA;
      for (int t = 0; t < 4; t++) begin
         wait_ack(0, which);
         chk("t2_order", which, t % 2);
         if (which == 0) chk("t2_dout0", {28'd0, a_dout0}, 32'hA);
         else            chk("t2_dout1", {28'd0, a_dout1}, 32'h5);
      end
      a_req0 = 1'b0; a_req1 = 1'b0;
      @(negedge clk);
      chk("t2_done", {24'd0, a_done}, 32'd4);
      chk("t2_idle", {31'd0, a_busy}, 32'd0);

      // ---------------- test 4: din change / req drop ignored ----------------
      a_req0 = 1'b1; a_din0 = 4'h1;
      @(negedge clk);                       // after grant edge
      a_din0 = 4'hE;
      @(negedge clk);                       // CAPTURE
      a_req0 = 1'b0;
      chk("t4_conv_latched", {28'd0, a_cin}, 32'h1);
      wait_ack(0, which);
      chk("t4_which", which, 0);
      chk("t4_dout0", {28'd0, a_dout0}, 32'hE);
      chk("t4_dout1_hold", {28'd0, a_dout1}, 32'h5);

      // ---------------- test 5: reset during DRIVE ----------------
      @(negedge clk);
      a_req1 = 1'b1; a_din1 = 4'h6;
      @(negedge clk);                       // in DRIVE
      chk("t5_drive", {31'd0, a_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy",  {31'd0, a_busy}, 32'd0);
      chk("t5_rst_conv",  {28'd0, a_cin}, 32'd0);
      chk("t5_rst_done",  {24'd0, a_done}, 32'd0);
      chk("t5_rst_dout0", {28'd0, a_dout0}, 32'd0);
      chk("t5_rst_dout1", {28'd0, a_dout1}, 32'd0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("t5_no_ack", {30'd0, a_ack1, a_ack0}, 32'd0);
      end
      rst_n = 1'b1;
      wait_ack(0, which);
      a_req1 = 1'b0;
      chk("t5_which", which, 1);
      chk("t5_dout1", {28'd0, a_dout1}, 32'h9);
      @(negedge clk);
      chk("t5_done", {24'd0, a_done}, 32'd1);

      // ---------------- test 3: SETTLE=4 latency ----------------
      b_req1 = 1'b1; b_din1 = 4'hF;
      for (int j = 0; j <= 6; j++) begin
         @(negedge clk);                    // after edge T+j
         b_req1 = 1'b0;
         chk("t3_ack1", {31'd0, b_ack1}, (j == 5) ? 32'd1 : 32'd0);
         chk("t3_ack0", {31'd0, b_ack0}, 32'd0);
         chk("t3_busy", {31'd0, b_busy}, (j <= 5) ? 32'd1 : 32'd0);
         if (j == 0) chk("t3_conv", {28'd0, b_cin}, 32'hF);
         if (j == 5) chk("t3_dout1", {28'd0, b_dout1}, 32'h0);
      end
      chk("t3_done", {24'd0, b_done}, 32'd1);

      // ---------------- test 6: done_cnt wrap, CNT_W=2 ----------------
      c_req0 = 1'b1; c_din0 = 4'h7;
      for (int t = 0; t < 5; t++) begin
         wait_ack(1, which);
         chk("t6_which", which, 0);
         chk("t6_dout0", {28'd0, c_dout0}, 32'h8);
         if (t == 4) c_req0 = 1'b0;
         @(negedge clk);
         chk("t6_done", {30'd0, c_done}, (t + 1) % 4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
